// File: rtl/figo_fsm.sv
// Serial detector for the "110", "101" and "010" patterns with a registered one-hot detect vector.
// Optional macro FIGO_NONOVERLAP_EN: each match restarts the history, so matches cannot overlap.
module figo_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic       inbit,
   output logic [2:0] detect
);

   // state  | meaning
   // S_IDLE | no bits seen since reset (or since the last match when non-overlapping)
   // S_0    | one bit seen, it was 0
   // S_1    | one bit seen, it was 1
   // S_00   | last two bits 0,0
   // S_01   | last two bits 0,1
   // S_10   | last two bits 1,0
   // S_11   | last two bits 1,1
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_0    = 3'd1,
      S_1    = 3'd2,
      S_00   = 3'd3,
      S_01   = 3'd4,
      S_10   = 3'd5,
      S_11   = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] detect_q, detect_d;
   logic       in_known;

   // An X/Z input freezes the FSM in simulation; synthesis sees this as constant 1.
   assign in_known = (inbit === 1'b0) || (inbit === 1'b1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         detect_q <= 3'b000;
      end else begin
         state_q  <= state_d;
         detect_q <= detect_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (in_known) begin
         case (state_q)
            S_IDLE:  state_d = inbit ? S_1  : S_0;
            S_0:     state_d = inbit ? S_01 : S_00;
            S_1:     state_d = inbit ? S_11 : S_10;
            S_00:    state_d = inbit ? S_01 : S_00;
            S_01:    state_d = inbit ? S_11 : S_10;
            S_10:    state_d = inbit ? S_01 : S_00;
            S_11:    state_d = inbit ? S_11 : S_10;
            default: state_d = S_IDLE;
         endcase
`ifdef FIGO_NONOVERLAP_EN
         if (detect_d != 3'b000) begin
            state_d = S_IDLE;
         end
`endif
      end
   end

   always_comb begin
      detect_d = 3'b000;
      if (in_known) begin
         case (state_q)
            S_11:    detect_d[0] = ~inbit;
            S_10:    detect_d[1] = inbit;
            S_01:    detect_d[2] = ~inbit;
            default: detect_d = 3'b000;
         endcase
      end
   end

   assign detect = detect_q;

endmodule

// File: tb/tb_figo_fsm.sv
// Self-checking bench for figo_fsm: directed vector table plus random stream against a bit-history model.
module tb_figo_fsm;

`ifdef FIGO_NONOVERLAP_EN
   localparam bit NONOV = 1'b1;
`else
   localparam bit NONOV = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       inbit;
   logic [2:0] detect;

   int checks   = 0;
   int failures = 0;

   figo_fsm dut (
      .clk    (clk),
      .reset  (reset),
      .inbit  (inbit),
      .detect (detect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       b;
      logic [2:0] exp;
      string      name;
   } vec_t;

   vec_t tbl[$];

   // Reference model: the bits seen since reset (or since the last match when non-overlapping).
   logic [2:0] m_hist;
   int         m_cnt;
   logic [2:0] m_exp;

   function automatic void model_update(input logic r, input logic b);
      if (r) begin
         m_cnt  = 0;
         m_hist = 3'b000;
         m_exp  = 3'b000;
      end else begin
         m_hist = {m_hist[1:0], b};
         m_cnt  = m_cnt + 1;
         m_exp  = 3'b000;
         if (m_cnt >= 3) begin
            if (m_hist == 3'b110) m_exp = 3'b001;
            if (m_hist == 3'b101) m_exp = 3'b010;
            if (m_hist == 3'b010) m_exp = 3'b100;
         end
         if (NONOV && m_exp != 3'b000) m_cnt = 0;
      end
   endfunction

   function automatic void add(input logic r, input logic b, input logic [2:0] e, input string nm);
      vec_t v;
      v.rst = r; v.b = b; v.exp = e; v.name = nm;
      tbl.push_back(v);
   endfunction

   task automatic step(input logic r, input logic b);
      reset = r;
      inbit = b;
      @(posedge clk);
      #1;
      model_update(r, b);
      checks++;
      if ($countones(detect) > 1) begin
         failures++;
         $display("FAIL mutex: detect=%b has more than one bit set", detect);
      end
   endtask

   initial begin
      reset = 1'b1;
      inbit = 1'b0;
      m_hist = 3'b000;
      m_cnt  = 0;
      m_exp  = 3'b000;

      add(1, 0, 3'b000, "rst_hold0");
      add(1, 1, 3'b000, "rst_hold1");
      add(0, 0, 3'b000, "zeros_a");
      add(0, 0, 3'b000, "zeros_b");
      add(0, 0, 3'b000, "zeros_c");

      add(1, 0, 3'b000, "rst");
      add(0, 1, 3'b000, "p110_b1");
      add(0, 1, 3'b000, "p110_b2");
      add(0, 0, 3'b001, "p110_hit");
      add(0, 0, 3'b000, "p110_after");

      add(1, 0, 3'b000, "rst");
      add(0, 1, 3'b000, "p101_b1");
      add(0, 0, 3'b000, "p101_b2");
      add(0, 1, 3'b010, "p101_hit");
      add(0, 0, NONOV ? 3'b000 : 3'b100, "p101_ovl_010");
      add(0, 1, NONOV ? 3'b000 : 3'b010, "p101_ovl_101");

      add(1, 0, 3'b000, "rst");
      add(0, 0, 3'b000, "p0110_b1");
      add(0, 1, 3'b000, "p0110_b2");
      add(0, 1, 3'b000, "p0110_b3");
      add(0, 0, 3'b001, "p0110_hit");

      add(1, 0, 3'b000, "rst");
      add(0, 0, 3'b000, "p010_b1");
      add(0, 1, 3'b000, "p010_b2");
      add(0, 0, 3'b100, "p010_hit");
      add(0, 1, NONOV ? 3'b000 : 3'b010, "p010_ovl_101");
      add(0, 0, NONOV ? 3'b000 : 3'b100, "p010_ovl_010");

      add(1, 0, 3'b000, "rst");
      add(0, 1, 3'b000, "midrst_b1");
      add(0, 1, 3'b000, "midrst_b2");
      add(1, 0, 3'b000, "midrst_rst");
      add(0, 0, 3'b000, "midrst_no110");

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].b);
         checks++;
         if (detect !== tbl[i].exp) begin
            failures++;
            $display("FAIL vec[%0d] %s: detect=%b expected=%b", i, tbl[i].name, detect, tbl[i].exp);
         end
      end

      // Back-to-back "110" matches: 1,1,0,1,1,0 pulses on bits 3 and 6, "101" at bit 4.
      step(1, 0);
      begin
         logic [5:0] seq;
         logic [2:0] want [6];
         seq = 6'b110110;
         want[0] = 3'b000; want[1] = 3'b000; want[2] = 3'b001;
         want[3] = NONOV ? 3'b000 : 3'b010;
         want[4] = 3'b000; want[5] = 3'b001;
         for (int i = 0; i < 6; i++) begin
            step(0, seq[5-i]);
            checks++;
            if (detect !== want[i]) begin
               failures++;
               $display("FAIL b2b[%0d]: detect=%b expected=%b", i, detect, want[i]);
            end
         end
      end

      // Random stream against the model, with occasional resets.
      step(1, 0);
      for (int i = 0; i < 3000; i++) begin
         logic r, b;
         r = ($urandom_range(0, 31) == 0);
         b = $urandom_range(0, 1);
         step(r, b);
         checks++;
         if (detect !== m_exp) begin
            failures++;
            $display("FAIL rand[%0d] rst=%b bit=%b: detect=%b expected=%b", i, r, b, detect, m_exp);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
